// File: rtl/tms3_peer_driver.sv
// Stimulus/closure partner for TestMasterSlave3: bursts NUM_WORDS strobed words and sums sampled responses.
// Optional TMS3_PEER_STALL_CHECK_EN adds a sticky stall_err flag for repeated consecutive responses.
module tms3_peer_driver #(
   parameter int unsigned NUM_WORDS   = 4,
   parameter int signed   STEP        = 1,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] seed,
   input  logic [31:0] peer_in,
   output logic [31:0] data_out,
   output logic        data_out_sync,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
`ifdef TMS3_PEER_STALL_CHECK_EN
   ,
   output logic        stall_err
`endif
);

   localparam int unsigned   WW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [15:0]   LAST_WORD = 16'(NUM_WORDS - 1);
   localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
   localparam logic [31:0]   STEP_W    = 32'(STEP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_r;
   logic [31:0]     base_r;
   logic [15:0]     word_cnt_r;
   logic [WW-1:0]   wait_cnt_r;
   logic [31:0]     word_val_s;
   logic [31:0]     sum_s;
`ifdef TMS3_PEER_STALL_CHECK_EN
   logic [31:0]     prev_r;
   logic            have_prev_r;
`endif

   // Next outgoing word and running response sum, both modulo 2^32.
   always_comb begin
      word_val_s = base_r + (32'(word_cnt_r) * STEP_W);
      sum_s      = result + peer_in;
   end

   // Burst sequencer with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= IDLE;
         base_r        <= 32'd0;
         word_cnt_r    <= 16'd0;
         wait_cnt_r    <= '0;
         data_out      <= 32'd0;
         data_out_sync <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         result        <= 32'd0;
`ifdef TMS3_PEER_STALL_CHECK_EN
         prev_r        <= 32'd0;
         have_prev_r   <= 1'b0;
         stall_err     <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  base_r     <= seed;
                  result     <= 32'd0;
                  word_cnt_r <= 16'd0;
                  busy       <= 1'b1;
`ifdef TMS3_PEER_STALL_CHECK_EN
                  have_prev_r <= 1'b0;
                  stall_err   <= 1'b0;
`endif
                  state_r    <= SEND;
               end
            end
            SEND: begin
               data_out      <= word_val_s;
               data_out_sync <= 1'b1;
               wait_cnt_r    <= '0;
               state_r       <= WAIT;
            end
            WAIT: begin
               data_out_sync <= 1'b0;
               wait_cnt_r    <= wait_cnt_r + WAIT_ONE;
               // peer_in only matters on the last WAIT edge of each word.
               if (wait_cnt_r == LAST_WAIT) begin
                  result <= sum_s;
`ifdef TMS3_PEER_STALL_CHECK_EN
                  if (have_prev_r && (peer_in == prev_r)) begin
                     stall_err <= 1'b1;
                  end
                  prev_r      <= peer_in;
                  have_prev_r <= 1'b1;
`endif
                  if (word_cnt_r == LAST_WORD) begin
                     state_r <= DONE;
                  end else begin
                     word_cnt_r <= word_cnt_r + 16'd1;
                     state_r    <= SEND;
                  end
               end
            end
            DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r       <= IDLE;
               data_out_sync <= 1'b0;
               busy          <= 1'b0;
               done          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tms3_peer_driver.sv
// Randomized self-checking bench for tms3_peer_driver; expectations come from closed-form burst timing.
module tb_tms3_peer_driver;

   localparam int N      = 4;
   localparam int W      = 2;
   localparam int P      = 1 + W;
   localparam int STEP_M = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] seed;
   logic [31:0] peer_in;
   logic [31:0] data_out;
   logic        data_out_sync;
   logic        busy;
   logic        done;
   logic [31:0] result;

   logic        start_c;
   logic [31:0] seed_c;
   logic [31:0] peer_c;
   logic [31:0] data_c;
   logic        sync_c;
   logic        busy_c;
   logic        done_c;
   logic [31:0] result_c;
`ifdef TMS3_PEER_STALL_CHECK_EN
   logic        stall_err;
   logic        stall_c;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] last_data;
   logic [31:0] word_peer [0:3];

   always #5 clk = ~clk;

   tms3_peer_driver u_dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .peer_in(peer_in),
      .data_out(data_out), .data_out_sync(data_out_sync), .busy(busy), .done(done),
      .result(result)
`ifdef TMS3_PEER_STALL_CHECK_EN
      , .stall_err(stall_err)
`endif
   );

   tms3_peer_driver #(.NUM_WORDS(1), .STEP(-3), .WAIT_CYCLES(1)) u_corner (
      .clk(clk), .rst(rst), .start(start_c), .seed(seed_c), .peer_in(peer_c),
      .data_out(data_c), .data_out_sync(sync_c), .busy(busy_c), .done(done_c),
      .result(result_c)
`ifdef TMS3_PEER_STALL_CHECK_EN
      , .stall_err(stall_c)
`endif
   );

   // peer_kind: 0 random every edge, 1 constant peer_const, 2 per-word from word_peer
   task automatic run_burst(input logic [31:0] seed_v, input int peer_kind,
                            input logic [31:0] peer_const, input int ignore_at, input int abort_at);
      int          total;
      int          k;
      int          ph;
      logic [31:0] exp_sum;
      logic [31:0] exp_data;
      logic [31:0] pv;
      logic [31:0] prev_s;
      logic        have_prev;
      logic        exp_stall;
      logic        exp_sync;
      total     = N * P + 1;
      exp_sum   = 32'd0;
      exp_data  = last_data;
      prev_s    = 32'd0;
      have_prev = 1'b0;
      exp_stall = 1'b0;
      seed      = seed_v;
      start     = 1'b1;
      peer_in   = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL start_done: got %b want 0", done); end
      n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL start_result: got %h want 0", result); end
      n_cmp++; if (data_out !== last_data) begin n_err++; $display("FAIL start_hold: got %h want %h", data_out, last_data); end
      n_cmp++; if (data_out_sync !== 1'b0) begin n_err++; $display("FAIL start_sync: got %b want 0", data_out_sync); end
`ifdef TMS3_PEER_STALL_CHECK_EN
      n_cmp++; if (stall_err !== 1'b0) begin n_err++; $display("FAIL start_stall: got %b want 0", stall_err); end
`endif
      for (int e = 1; e <= total; e++) begin
         k  = (e < total) ? (e - 1) / P : N - 1;
         ph = (e - 1) % P;
         case (peer_kind)
            0:       pv = $urandom;
            1:       pv = peer_const;
            default: pv = word_peer[k];
         endcase
         peer_in = pv;
         start   = (e == ignore_at);
         @(posedge clk); #1;
         if (e < total && ph == W) begin
            if (have_prev && pv == prev_s) exp_stall = 1'b1;
            prev_s    = pv;
            have_prev = 1'b1;
            exp_sum   = exp_sum + pv;
         end
         exp_data = seed_v + 32'(k) * 32'(STEP_M);
         exp_sync = (e < total) && (ph == 0);
         n_cmp++; if (data_out !== exp_data) begin n_err++; $display("FAIL data_out e=%0d: got %h want %h", e, data_out, exp_data); end
         n_cmp++; if (data_out_sync !== exp_sync) begin n_err++; $display("FAIL sync e=%0d: got %b want %b", e, data_out_sync, exp_sync); end
         n_cmp++; if (busy !== (e < total)) begin n_err++; $display("FAIL busy e=%0d: got %b want %b", e, busy, e < total); end
         n_cmp++; if (done !== (e == total)) begin n_err++; $display("FAIL done e=%0d: got %b want %b", e, done, e == total); end
         n_cmp++; if (result !== exp_sum) begin n_err++; $display("FAIL result e=%0d: got %h want %h", e, result, exp_sum); end
`ifdef TMS3_PEER_STALL_CHECK_EN
         n_cmp++; if (stall_err !== exp_stall) begin n_err++; $display("FAIL stall e=%0d: got %b want %b", e, stall_err, exp_stall); end
`endif
         if (e == abort_at) begin
            rst = 1'b0;
            #2;
            n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL abort_data: got %h want 0", data_out); end
            n_cmp++; if (data_out_sync !== 1'b0) begin n_err++; $display("FAIL abort_sync: got %b want 0", data_out_sync); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
            n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL abort_result: got %h want 0", result); end
`ifdef TMS3_PEER_STALL_CHECK_EN
            n_cmp++; if (stall_err !== 1'b0) begin n_err++; $display("FAIL abort_stall: got %b want 0", stall_err); end
`endif
            exp_data = 32'd0;
            break;
         end
      end
      start     = 1'b0;
      last_data = exp_data;
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; seed = 32'd0; peer_in = 32'd0;
      start_c = 1'b0; seed_c = 32'd0; peer_c = 32'd0;
      last_data = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (data_out !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", data_out); end
      n_cmp++; if (data_out_sync !== 1'b0) begin n_err++; $display("FAIL rst_sync: got %b want 0", data_out_sync); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
      n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL rst_result: got %h want 0", result); end
      n_cmp++; if (busy_c !== 1'b0 || done_c !== 1'b0 || sync_c !== 1'b0) begin n_err++; $display("FAIL rst_corner: got %b%b%b want 000", busy_c, done_c, sync_c); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic;
      run_burst(32'd100, 1, 32'd10, -1, -1);
      n_cmp++; if (result !== 32'd40) begin n_err++; $display("FAIL basic_result: got %0d want 40", result); end
      n_cmp++; if (data_out !== 32'd103) begin n_err++; $display("FAIL basic_last: got %0d want 103", data_out); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b want 0", done); end
      n_cmp++; if (data_out !== 32'd103) begin n_err++; $display("FAIL hold_after: got %0d want 103", data_out); end
   endtask

   task automatic test_wrap;
      run_burst(32'h7FFF_FFFF, 1, 32'hFFFF_FFFF, -1, -1);
      n_cmp++; if (result !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_result: got %h want fffffffc", result); end
      n_cmp++; if (data_out !== 32'h8000_0002) begin n_err++; $display("FAIL wrap_last: got %h want 80000002", data_out); end
   endtask

   task automatic test_random;
      for (int i = 0; i < 4; i++) begin
         run_burst($urandom, 0, 32'd0, -1, -1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_ignored_start;
      run_burst($urandom, 0, 32'd0, 5, -1);
   endtask

   task automatic test_back_to_back;
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_in_done: got %b want 1", done); end
      run_burst($urandom, 1, 32'd3, 9, -1);
      n_cmp++; if (result !== 32'd12) begin n_err++; $display("FAIL b2b_result: got %0d want 12", result); end
   endtask

   task automatic test_reset_mid;
      // edge 8 is the first WAIT edge of word 2
      run_burst($urandom, 0, 32'd0, -1, 8);
      rst = 1'b1;
      run_burst($urandom, 0, 32'd0, -1, -1);
   endtask

`ifdef TMS3_PEER_STALL_CHECK_EN
   task automatic test_stall;
      word_peer[0] = 32'd5; word_peer[1] = 32'd5; word_peer[2] = 32'd6; word_peer[3] = 32'd7;
      run_burst($urandom, 2, 32'd0, -1, -1);
      n_cmp++; if (stall_err !== 1'b1) begin n_err++; $display("FAIL stall_set: got %b want 1", stall_err); end
      word_peer[0] = 32'd1; word_peer[1] = 32'd2; word_peer[2] = 32'd3; word_peer[3] = 32'd4;
      run_burst($urandom, 2, 32'd0, -1, -1);
      n_cmp++; if (stall_err !== 1'b0) begin n_err++; $display("FAIL stall_clear: got %b want 0", stall_err); end
   endtask
`endif

   task automatic test_corner;
      logic [31:0] s;
      logic [31:0] pc;
      s = $urandom;
      seed_c = s; start_c = 1'b1; peer_c = $urandom;
      @(posedge clk); #1;
      start_c = 1'b0;
      n_cmp++; if (busy_c !== 1'b1 || sync_c !== 1'b0) begin n_err++; $display("FAIL c_e0: got busy=%b sync=%b want 1 0", busy_c, sync_c); end
      peer_c = $urandom;
      @(posedge clk); #1;
      n_cmp++; if (sync_c !== 1'b1 || data_c !== s) begin n_err++; $display("FAIL c_e1: got sync=%b data=%h want 1 %h", sync_c, data_c, s); end
      pc = $urandom;
      peer_c = pc;
      @(posedge clk); #1;
      n_cmp++; if (sync_c !== 1'b0 || result_c !== pc || done_c !== 1'b0) begin n_err++; $display("FAIL c_e2: got sync=%b res=%h done=%b want 0 %h 0", sync_c, result_c, done_c, pc); end
      peer_c = $urandom;
      @(posedge clk); #1;
      n_cmp++; if (done_c !== 1'b1 || busy_c !== 1'b0 || result_c !== pc || data_c !== s) begin n_err++; $display("FAIL c_e3: got done=%b busy=%b res=%h data=%h want 1 0 %h %h", done_c, busy_c, result_c, data_c, pc, s); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_random();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
`ifdef TMS3_PEER_STALL_CHECK_EN
      test_stall();
`endif
      test_corner();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tms3_peer_driver.md
Name: tms3_peer_driver

Overview:
- Counterpart to the TestMasterSlave3 block.
- Drives its slave-style input pair: a data word plus a one-cycle sync strobe, which connect to s_in / s_in_sync.
- Samples its master-style output, which connects to s_out and is always valid.
- Sends a burst of NUM_WORDS words on start and accumulates the partner's responses; used as the stimulus/closure end in integration and equivalence benches.

Parameters:
- NUM_WORDS, 4, words per burst (1..65535).
- STEP, 1, signed 32-bit increment added per word.
- WAIT_CYCLES, 2, cycles between strobe and response sampling (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begin burst; sampled only in IDLE.
- seed  in  32  signed first data word, latched on accepted start.
- peer_in  in  32  partner s_out, always valid.
- data_out  out  32  to partner s_in.
- data_out_sync  out  1  to partner s_in_sync; one-cycle strobe.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at burst end.
- result  out  32  sum of sampled peer_in values, modulo 2^32.

Behaviour:
- Reset (rst=0, async), all registered:
  - state = IDLE
  - data_out = 0, data_out_sync = 0, busy = 0, done = 0, result = 0
  - word and wait counters = 0
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - done <= 0.
  - start=1 -> latch seed into base, result <= 0, word_cnt <= 0, busy <= 1, go SEND.
  - start=0 -> stay.
- SEND:
  - data_out <= base + word_cnt*STEP, truncated to 32 bits (two's complement wrap, no saturation).
  - data_out_sync <= 1, wait_cnt <= 0, go WAIT.
- WAIT:
  - data_out_sync <= 0 on the first WAIT edge, so the strobe is exactly one cycle.
  - data_out holds its value.
  - wait_cnt increments each edge.
  - At the edge where wait_cnt == WAIT_CYCLES-1: result <= result + peer_in (wrap).
  - Then, if word_cnt == NUM_WORDS-1, go DONE; else word_cnt++ and go SEND.
- DONE: done <= 1, busy <= 0, go IDLE. done clears on the next edge.
- Timing:
  - Each word takes 1+WAIT_CYCLES edges.
  - With start sampled at edge 0, done is high after edge 1+NUM_WORDS*(1+WAIT_CYCLES); with defaults, after edge 13.
  - Strobes are never back-to-back: at least WAIT_CYCLES low cycles between them.
- start while busy is ignored; no queueing.
- start asserted in the cycle done is high is accepted (state is IDLE at that edge).
- data_out keeps its last value after the burst until the next SEND or reset.
- Reset asserted mid-burst aborts immediately with reset values; no done pulse.
- peer_in is sampled only at the final WAIT edge; values at other times are ignored.

Optional Feature:
- Macro TMS3_PEER_STALL_CHECK_EN.
- When defined:
  - Adds output stall_err (1 bit, reset 0).
  - Set sticky when a sampled peer_in equals the previous sample within the same burst; the first sample of a burst is never compared.
  - Cleared only by reset or by an accepted start.
- When undefined: no stall_err port, no compare register; all other behaviour is identical.

Test Plan:
- Reset during operation: assert rst=0 mid-WAIT of word 2 -> all outputs 0 next sample, state IDLE; release, start again -> full burst completes normally.
- Basic burst: defaults, seed=100, peer_in tied to 10, start pulse -> data_out sequence 100,101,102,103, each with one-cycle sync, strobes 3 cycles apart; done high after edge 13; result=40; busy low with done.
- Wrap: seed=0x7FFFFFFF, STEP=1 -> second word 0x80000000; peer_in=0xFFFFFFFF constant -> result=0xFFFFFFFC.
- Ignored start: pulse start again mid-burst -> no restart, word count and result unchanged; start during the done cycle -> new burst begins, result cleared to 0.
- Stall check (macro defined): peer_in = 5,5,6,7 across samples -> stall_err set after the 2nd sample and stays 1; next start clears it. With peer_in = 1,2,3,4 -> stall_err stays 0.
- Parameter corner: NUM_WORDS=1, WAIT_CYCLES=1 -> single strobe, sample one edge later, done high after edge 3.
